mmio_io_ctrl: RTL and testbench

- Memory-mapped I/O controller directly downstream of the processor data-memory port.
- Decodes processor loads and stores to the I/O window.
- Owns the HEX, LEDR and LEDG output registers and drives the six seven-segment displays.
- Synchronizes and debounces the KEY and SW board inputs and returns them on loads.

---
 rtl/mmio_io_ctrl_if.sv | 27 ++
 rtl/mmio_io_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_mmio_io_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_io_ctrl_if.sv
// Processor data-memory port as seen by the MMIO controller.
// The processor side drives address, store strobe and store data;
// the controller side returns registered load data.
`timescale 1ns/1ps

interface mmio_io_ctrl_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             we;
    logic [DBITS-1:0] wdata;
    logic [DBITS-1:0] rdata;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller for the board peripherals.
// Owns the HEX/LEDR/LEDG output registers, drives six seven-segment
// displays and returns synchronized, debounced KEY/SW state on loads.
// Optional build macro MMIO_KEY_EDGE_CAPTURE_EN adds a sticky,
// write-1-to-clear press-event register in bits [7:4] of the KEY word.
`timescale 1ns/1ps

// Synchronizes and debounces one group of inputs with a shared counter.
module mmio_io_ctrl_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEBOUNCE_BITS   = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] stable_next
);
    localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST = DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE  = DEBOUNCE_BITS'(1);

    logic [WIDTH-1:0]         meta_q, meta_d;
    logic [WIDTH-1:0]         sync_q, sync_d;
    logic [WIDTH-1:0]         prev_q, prev_d;
    logic [WIDTH-1:0]         stable_q, stable_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer, change detector and acceptance counter.
    always_comb begin
        meta_d   = raw;
        sync_d   = meta_q;
        prev_d   = sync_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if ((sync_q != prev_q) || (sync_q == stable_q)) begin
            // Input moving, or nothing new to accept: restart the window.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Held long enough; the compare also keeps the counter from wrapping.
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Input-path state; reset discards any change still being qualified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable      = stable_q;
    assign stable_next = stable_d;
endmodule

module mmio_io_ctrl #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               DEBOUNCE_BITS   = 20
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    mmio_io_ctrl_if.slave        bus,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SW,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5
);
    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [23:0]      hex_q, hex_d;
    logic [9:0]       ledr_q, ledr_d;
    logic [7:0]       ledg_q, ledg_d;
    logic [DBITS-1:0] rdata_q, rdata_d;

    logic [3:0]       key_db, key_db_next;
    logic [9:0]       sw_db, sw_db_next_unused;

    logic hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw;

    // Only the low 24 store-data bits ever reach a register.
    wire unused_wdata_hi = ^bus.wdata[DBITS-1:24];

    // Buttons are debounced in pressed=1 polarity so reset reads as released.
    mmio_io_ctrl_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_BITS   (DEBOUNCE_BITS)
    ) u_key_db (
        .clk         (CLOCK_50),
        .rst         (RESET),
        .raw         (~KEY),
        .stable      (key_db),
        .stable_next (key_db_next)
    );

    mmio_io_ctrl_debounce #(
        .WIDTH           (10),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_BITS   (DEBOUNCE_BITS)
    ) u_sw_db (
        .clk         (CLOCK_50),
        .rst         (RESET),
        .raw         (SW),
        .stable      (sw_db),
        .stable_next (sw_db_next_unused)
    );

    // Full-width address decode; every register lives at exactly one address.
    always_comb begin
        hit_hex  = (bus.addr == ADDR_HEX);
        hit_ledr = (bus.addr == ADDR_LEDR);
        hit_ledg = (bus.addr == ADDR_LEDG);
        hit_key  = (bus.addr == ADDR_KEY);
        hit_sw   = (bus.addr == ADDR_SW);
    end

`ifdef MMIO_KEY_EDGE_CAPTURE_EN
    logic [3:0] key_evt_q, key_evt_d;

    // Sticky press events: W1C from the bus, a new press beats a same-cycle clear.
    always_comb begin
        key_evt_d = key_evt_q;
        if (bus.we && hit_key) begin
            key_evt_d = key_evt_d & ~bus.wdata[7:4];
        end
        key_evt_d = key_evt_d | (key_db_next & ~key_db);
    end

    // Event register state.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_evt_q <= '0;
        end else begin
            key_evt_q <= key_evt_d;
        end
    end
`else
    wire unused_key_db_next = ^key_db_next;
`endif

    // Store path into the output registers and load-data select.
    always_comb begin
        hex_d   = hex_q;
        ledr_d  = ledr_q;
        ledg_d  = ledg_q;
        rdata_d = '0;

        if (bus.we && hit_hex)  hex_d  = bus.wdata[23:0];
        if (bus.we && hit_ledr) ledr_d = bus.wdata[9:0];
        if (bus.we && hit_ledg) ledg_d = bus.wdata[7:0];

        // Loads see the register values before any same-cycle store.
        if (hit_hex) begin
            rdata_d[23:0] = hex_q;
        end else if (hit_ledr) begin
            rdata_d[9:0] = ledr_q;
        end else if (hit_ledg) begin
            rdata_d[7:0] = ledg_q;
        end else if (hit_key) begin
`ifdef MMIO_KEY_EDGE_CAPTURE_EN
            rdata_d[7:0] = {key_evt_q, key_db};
`else
            rdata_d[3:0] = key_db;
`endif
        end else if (hit_sw) begin
            rdata_d[9:0] = sw_db;
        end
    end

    // Output registers and registered load data.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            hex_q   <= '0;
            ledr_q  <= '0;
            ledg_q  <= '0;
            rdata_q <= '0;
        end else begin
            hex_q   <= hex_d;
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign LEDR      = ledr_q;
    assign LEDG      = ledg_q;
    assign HEX0      = seg7(hex_q[3:0]);
    assign HEX1      = seg7(hex_q[7:4]);
    assign HEX2      = seg7(hex_q[11:8]);
    assign HEX3      = seg7(hex_q[15:12]);
    assign HEX4      = seg7(hex_q[19:16]);
    assign HEX5      = seg7(hex_q[23:20]);
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl with a register-level reference model.
`timescale 1ns/1ps

module tb_mmio_io_ctrl;
    localparam int DC = 4;
    localparam int DB = 3;
    localparam logic [31:0] A_HEX  = 32'hF0000000;
    localparam logic [31:0] A_LEDR = 32'hF0000004;
    localparam logic [31:0] A_LEDG = 32'hF0000008;
    localparam logic [31:0] A_KEY  = 32'hF0000010;
    localparam logic [31:0] A_SW   = 32'hF0000014;
    localparam logic [31:0] A_BAD  = 32'hF000000C;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [7:0] LEDG;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    mmio_io_ctrl_if #(.DBITS(32)) bus();

    mmio_io_ctrl #(
        .DBITS(32), .DEBOUNCE_CYCLES(DC), .DEBOUNCE_BITS(DB)
    ) dut (
        .CLOCK_50(clk), .RESET(rst), .bus(bus), .KEY(KEY), .SW(SW),
        .LEDR(LEDR), .LEDG(LEDG),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [23:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_key;
    logic [9:0]  m_sw;
    logic [3:0]  m_evt;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == A_HEX)  return {8'b0, m_hex};
        if (a == A_LEDR) return {22'b0, m_ledr};
        if (a == A_LEDG) return {24'b0, m_ledg};
`ifdef MMIO_KEY_EDGE_CAPTURE_EN
        if (a == A_KEY)  return {24'b0, m_evt, m_key};
`else
        if (a == A_KEY)  return {28'b0, m_key};
`endif
        if (a == A_SW)   return {22'b0, m_sw};
        return 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (a == A_HEX)  m_hex  = d[23:0];
        if (a == A_LEDR) m_ledr = d[9:0];
        if (a == A_LEDG) m_ledg = d[7:0];
`ifdef MMIO_KEY_EDGE_CAPTURE_EN
        if (a == A_KEY)  m_evt  = m_evt & ~d[7:4];
`endif
    endtask

    function automatic logic [41:0] model_hex();
        logic [41:0] h;
        for (int i = 0; i < 6; i++) h[7*i +: 7] = SEG[m_hex[4*i +: 4]];
        return h;
    endfunction

    task automatic model_reset();
        m_hex = '0; m_ledr = '0; m_ledg = '0; m_key = '0; m_sw = '0; m_evt = '0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          due;
        int          kind;
        logic [41:0] exp;
        string       name;
    } exp_t;
    exp_t sbq[$];

    task automatic push(input int kind, input logic [41:0] exp, input string name);
        exp_t e;
        e.due = cyc + 1; e.kind = kind; e.exp = exp; e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: compares every expectation whose response is now on the outputs.
    always @(negedge clk) begin
        exp_t e;
        logic [41:0] act;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            case (e.kind)
                0:       act = 42'(bus.rdata);
                1:       act = 42'(LEDR);
                2:       act = 42'(LEDG);
                default: act = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
            endcase
            check(e.name, act, e.exp);
        end
    end

    // One bus cycle: drive, record expected load data, then apply the store.
    task automatic op(input logic [31:0] a, input logic w, input logic [31:0] d, input bit chk);
        @(negedge clk);
        bus.addr = a; bus.we = w; bus.wdata = d;
        if (chk) push(0, 42'(model_read(a)), "rdata");
        if (w) model_write(a, d);
        push(1, 42'(m_ledr), "ledr");
        push(2, 42'(m_ledg), "ledg");
        push(3, model_hex(), "hex");
    endtask

    // Change pins and hold them well past the debounce window.
    task automatic set_inputs(input logic [3:0] key, input logic [9:0] sw);
        logic [3:0] old_key;
        KEY = key; SW = sw;
        for (int i = 0; i < 12; i++) op(A_LEDR, 1'b0, 32'h0, 1'b1);
        old_key = m_key;
        m_key = ~key; m_sw = sw;
        m_evt = m_evt | (m_key & ~old_key);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) @(negedge clk);
    endtask

    int first;
    logic [31:0] r, a;
    logic [31:0] addrs [6];

    initial begin
        addrs = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_SW, A_BAD};
        rst = 1'b1; KEY = 4'hF; SW = 10'h0;
        bus.addr = 32'h0; bus.we = 1'b0; bus.wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ledr", 42'(LEDR), 42'h0);
        check("rst_ledg", 42'(LEDG), 42'h0);
        check("rst_rdata", 42'(bus.rdata), 42'h0);
        check("rst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h40}});
        rst = 1'b0;

        // Register stores and loads
        op(A_LEDR, 1'b1, 32'hFFFFFFFF, 1'b1);
        op(A_LEDG, 1'b1, 32'h00000012, 1'b1);
        op(A_HEX,  1'b1, 32'h00A5C3F0, 1'b1);
        op(A_LEDR, 1'b0, 32'h0, 1'b1);
        op(A_LEDG, 1'b0, 32'h0, 1'b1);
        op(A_HEX,  1'b0, 32'h0, 1'b1);
        op(A_LEDR, 1'b0, 32'h0, 1'b1);
        drain();

        // Asynchronous reset between clock edges
        @(posedge clk); #3;
        rst = 1'b1; #1;
        check("async_rst_ledr", 42'(LEDR), 42'h0);
        check("async_rst_ledg", 42'(LEDG), 42'h0);
        check("async_rst_rdata", 42'(bus.rdata), 42'h0);
        check("async_rst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h40}});
        @(negedge clk); rst = 1'b0;
        model_reset();

        // SW debounce latency
        op(A_SW, 1'b0, 32'h0, 1'b1);
        drain();
        @(negedge clk);
        SW = 10'h2AA; bus.addr = A_SW; bus.we = 1'b0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (first < 0 && bus.rdata == 32'h2AA) first = i;
        end
        checks++;
        if (first < 6 || first > 8) begin
            failures++;
            $display("FAIL sw_latency edges=%0d required 6..8", first);
        end
        m_sw = 10'h2AA;

        // 3-cycle glitch must not be accepted
        SW = 10'h001;
        for (int i = 0; i < 3; i++) op(A_SW, 1'b0, 32'h0, 1'b1);
        SW = 10'h2AA;
        for (int i = 0; i < 10; i++) op(A_SW, 1'b0, 32'h0, 1'b1);

        // KEY and unmapped accesses
        set_inputs(4'b1110, 10'h2AA);
        op(A_KEY, 1'b0, 32'h0, 1'b1);
        op(A_BAD, 1'b0, 32'h0, 1'b1);
        op(A_SW, 1'b1, 32'hFFFFFFFF, 1'b1);
        op(A_BAD, 1'b1, 32'hFFFFFFFF, 1'b1);
        op(A_KEY, 1'b1, 32'h0000000F, 1'b1);
        op(A_KEY, 1'b0, 32'h0, 1'b1);

`ifdef MMIO_KEY_EDGE_CAPTURE_EN
        // Sticky press events
        set_inputs(4'b1111, 10'h2AA);
        op(A_KEY, 1'b1, 32'h000000F0, 1'b1);
        set_inputs(4'b1011, 10'h2AA);
        set_inputs(4'b1111, 10'h2AA);
        set_inputs(4'b1011, 10'h2AA);
        set_inputs(4'b1111, 10'h2AA);
        op(A_KEY, 1'b0, 32'h0, 1'b1);
        op(A_KEY, 1'b1, 32'h00000040, 1'b1);
        op(A_KEY, 1'b0, 32'h0, 1'b1);
        op(A_KEY, 1'b0, 32'h0, 1'b1);
        drain();
        // Press lands while the clear is being written every cycle
        @(negedge clk);
        KEY = 4'b1011; bus.addr = A_KEY; bus.we = 1'b1; bus.wdata = 32'h40;
        first = -1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (first < 0 && bus.rdata[2]) begin
                first = i;
                check("evt_set_wins", 42'(bus.rdata), 42'h44);
            end
        end
        check("evt_cleared_after", 42'(bus.rdata), 42'h04);
        @(negedge clk); bus.we = 1'b0;
        m_key = 4'b0100; m_evt = 4'b0000;
        op(A_KEY, 1'b0, 32'h0, 1'b1);
`endif

        // Same-cycle load and store
        op(A_LEDR, 1'b1, 32'h005, 1'b1);
        op(A_LEDR, 1'b1, 32'h00A, 1'b1);
        op(A_LEDR, 1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            if (n % 50 == 25) begin
                r = $urandom;
                set_inputs(r[3:0], r[13:4]);
            end
            r = $urandom_range(0, 7);
            if (r < 6) a = addrs[r];
            else if (r == 6) begin r = $urandom; a = {24'hF00000, r[7:0]}; end
            else a = $urandom;
            r = $urandom;
            op(a, r[0], $urandom, 1'b1);
        end
        op(A_LEDR, 1'b0, 32'h0, 1'b1);
        drain();
        check("sb_drain", 42'(sbq.size()), 42'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
